trace_sampler: RTL

TRACE_SAMPLER -- requirements
Module: trace_sampler

---
 rtl/trace_pkg.sv | 21 ++
 rtl/trace_fifo.sv | 58 +++++
 rtl/trace_sampler.sv | 123 ++++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared state encoding, entry layout and default sizes for the trace sampler
package trace_pkg;

  localparam int DEF_DATA_W  = 64;
  localparam int DEF_CYCLE_W = 64;
  localparam int DEF_DEPTH   = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CAPTURE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [DEF_CYCLE_W-1:0] cycle;
    logic [DEF_DATA_W-1:0]  data;
  } entry_t;

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - capture FIFO with wrap-bit pointers and a synchronous flush
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_CYCLE_W + DEF_DATA_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Head reads as zero when empty so stale memory never leaks onto the outputs.
  assign pop_data = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PTR_ONE;
      if (do_pop)  rd_d = rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush) mem_q[wr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/trace_sampler.sv
// rtl/trace_sampler.sv - records a window of target I/O tokens with their target-cycle stamps
module trace_sampler
  import trace_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CYCLE_W = DEF_CYCLE_W,
  parameter int DEPTH   = DEF_DEPTH
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               arm,
  input  logic               abort,
  input  logic [CYCLE_W-1:0] cfg_start,
  input  logic [31:0]        cfg_len,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [CYCLE_W-1:0] out_cycle,
  output logic               busy,
  output logic               done
);
  localparam int ENTRY_W = CYCLE_W + DATA_W;

  state_t               state_q, state_d;
  logic [CYCLE_W-1:0]   tcycle_q, tcycle_d, start_q, start_d;
  logic [31:0]          len_q, len_d, count_q, count_d;
  logic                 fire, push, flush, fifo_full, fifo_empty, rec_hit;
  logic [ENTRY_W-1:0]   head;

  assign fire      = in_valid && in_ready;
  assign rec_hit   = (tcycle_q == start_q);
  assign tcycle_d  = tcycle_q + {{(CYCLE_W-1){1'b0}}, fire};
  assign out_valid = !fifo_empty;
  assign {out_cycle, out_data} = head;
  assign busy      = (state_q == ST_WAIT) || (state_q == ST_CAPTURE) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);

  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    len_d    = len_q;
    count_d  = count_q;
    push     = 1'b0;
    flush    = 1'b0;
    in_ready = 1'b1;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          start_d = cfg_start;
          len_d   = cfg_len;
          count_d = '0;
          if (cfg_len == 32'd0)          state_d = ST_DRAIN;
          else if (tcycle_q >= cfg_start) state_d = ST_CAPTURE;
          else                            state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Only the fire carrying the start stamp can be stalled by a full FIFO.
        if (rec_hit) begin
          in_ready = !fifo_full;
          if (in_valid && !fifo_full) begin
            push    = 1'b1;
            count_d = 32'd1;
            state_d = (len_q == 32'd1) ? ST_DRAIN : ST_CAPTURE;
          end
        end
      end
      ST_CAPTURE: begin
        in_ready = !fifo_full;
        if (in_valid && !fifo_full) begin
          push    = 1'b1;
          count_d = count_q + 32'd1;
          if (count_q + 32'd1 == len_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
      count_d = '0;
      push    = 1'b0;
      flush   = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      tcycle_q <= '0;
      start_q  <= '0;
      len_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      tcycle_q <= tcycle_d;
      start_q  <= start_d;
      len_q    <= len_d;
      count_q  <= count_d;
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush),
    .push      (push),
    .push_data ({tcycle_q, in_data}),
    .pop       (out_valid && out_ready),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
